decode_module: RTL and testbench
================================

# decode_module

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of `Fetch_module`. It consumes the IF/ID register (`pc`, `instr`), holds the 32×32 register file, and generates control. It resolves branches and jumps in ID and drives their target, taken and flush signals back to fetch. It detects load-use and branch-operand hazards, stalls fetch through `pc_we`/`if_id_we`, and registers everything the execute stage needs into the ID/EX pipeline register.

## Interface
- `NB_BITS`, 32, datapath width
- `NB_REG`, 5, register-address width
- `NB_CTRL`, 11, width of the ID/EX control word (field layout in package)

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  reset; asynchronous and active-low
- `i_if_id_pc`  in  32  PC+4 of the instruction in ID
- `i_if_id_instr`  in  32  instruction in ID
- `i_wb_we` / `i_wb_addr` / `i_wb_data`  in  1/5/32  register-file write port from WB
- `i_ex_mem_rd` / `i_ex_mem_reg_write` / `i_ex_mem_mem_read`  in  5/1/1  EX/MEM destination info, used for hazard checks
- `i_ex_mem_alu_result`  in  32  forwarded into the branch comparator
- `o_brq_addr` / `o_jmp_addr`  out  32/32  branch and jump targets to fetch
- `o_ctr_beq` / `o_ctr_jmp` / `o_ctr_flush`  out  1  taken branch, taken jump, and flush of IF/ID
- `o_pc_we` / `o_if_id_we`  out  1  fetch write enables; 0 = stall
- `o_id_ex_pc`, `o_id_ex_rs_data`, `o_id_ex_rt_data`, `o_id_ex_imm`  out  32 each  registered to EX
- `o_id_ex_rs`, `o_id_ex_rt`, `o_id_ex_rd`, `o_id_ex_shamt`  out  5 each
- `o_id_ex_funct`  out  6
- `o_id_ex_ctrl`  out  `NB_CTRL`  bundle of: `reg_dst[1:0]` (0=rt, 1=rd, 2=r31), `alu_src`, `alu_op[3:0]`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write`

## Operation
- Supported instructions: R-type, JR, ADDI, ANDI, ORI, XORI, SLTI, LUI, LW, SW, BEQ, BNE, J, JAL. Any other opcode decodes as a NOP with a control word of all zeros.
- Immediate extension: sign-extended for ADDI, SLTI, LW, SW, BEQ and BNE; zero-extended for ANDI, ORI and XORI; LUI yields `{imm,16'h0}`.
- Register file:
  - r0 reads 0 and ignores writes.
  - Writes occur on the rising edge.
  - A same-cycle read of the address being written returns `i_wb_data` (internal bypass).
- Branch comparator operands are forwarded from `i_ex_mem_alu_result` when `i_ex_mem_reg_write` is set, `i_ex_mem_mem_read` is clear, and `i_ex_mem_rd` matches a nonzero source register. Otherwise the operands come from the register file.
- Targets:
  - `o_brq_addr = pc4 + (sext(imm)<<2)`.
  - `o_jmp_addr = {pc4[31:28], instr[25:0], 2'b00}` for J and JAL; the rs value for JR.
- Taken BEQ/BNE asserts `o_ctr_beq` and `o_ctr_flush`. J, JAL and JR assert `o_ctr_jmp` and `o_ctr_flush`.
- JAL writes r31 with `reg_dst=2`; EX selects `o_id_ex_pc` as the link value.
- Stall conditions:
  - (a) ID/EX holds a `mem_read` and its rt matches a used nonzero rs or rt in ID.
  - (b) A branch or JR in ID uses a register written by the ID/EX instruction.
  - (c) A branch or JR in ID uses a register loaded by the EX/MEM instruction (`i_ex_mem_mem_read`).
- On a stall: `o_pc_we=0`, `o_if_id_we=0`, the ID/EX control word loads zeros (bubble), and branch/jump/flush outputs are forced to 0. A stall overrides a simultaneous branch decision.

## Timing
- Control and fetch-feedback outputs are combinational from IF/ID and the hazard inputs, and are valid within the same cycle.
- Redirect: a taken branch/jump is seen by fetch on the next edge. The branch itself enters ID/EX with its own control word; its `reg_write` is 0 except for JAL.
- ID/EX loads on every rising edge; there is no enable.
- Reset (`i_rst`=0), asynchronous: every ID/EX output is 0 and every register-file entry is 0. With IF/ID equal to 0 (sll r0 NOP), the combinational outputs settle to `o_pc_we=1`, `o_if_id_we=1`, and `o_ctr_*=0`.
- Reset asserted mid-stall clears the bubble and the stall immediately.

## Configuration
- `DECODE_DEBUG_EN`:
  - Defined: adds ports `i_dbg_reg_addr` (5) and `o_dbg_reg_data` (32), an asynchronous read port on the register file for the debug unit, with no effect on the pipeline.
  - Undefined: the ports and logic are absent.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - `alu_op` encodings;
  - the `reg_dst` encodings;
  - bit positions of the `o_id_ex_ctrl` fields;
  - `NB_CTRL`.
- Sub-module `reg_file` contains the 32×32 storage, the write-through bypass and the optional debug port. Control decode, hazard detection and the ID/EX register stay in `decode_module`.

## Test plan
- Reset, then `ADDI r1,r0,5` with WB writing r1=5: next edge gives `o_id_ex_imm=5`, `alu_src=1`, `reg_write=1`, `reg_dst=0`, `o_id_ex_rt=1`.
- Same-cycle WB write r2=0x1234 while decoding `ADD r3,r2,r0`: `o_id_ex_rs_data=0x1234` after the edge.
- `LW r4,0(r0)` followed by `ADD r5,r4,r4`: one cycle with `o_pc_we=0` and `o_if_id_we=0`, a zero control word in ID/EX, then the ADD passes normally.
- `BEQ r1,r1,+3` at PC+4=0x20: `o_ctr_beq=1`, `o_ctr_flush=1`, `o_brq_addr=0x2C`. Same case with r1 in ID/EX being written: one stall cycle first and `o_ctr_beq=0` during it.
- `JAL 0x40` at PC+4=0x10: `o_ctr_jmp=1`, `o_jmp_addr=0x100`; ID/EX gets `reg_dst=2`, `reg_write=1`, `o_id_ex_pc=0x10`.
- Drive `i_rst` low during a load-use stall: all `o_id_ex_*` go to 0 asynchronously and `o_pc_we` returns to 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS pipeline.
// Contents: opcode and funct constants, ALU operation codes, reg_dst codes,
// bit positions of the ID/EX control word, and a control-word packer.
package mips_pkg;

  localparam int NB_BITS = 32;
  localparam int NB_REG  = 5;
  localparam int NB_CTRL = 11;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes that decode needs to distinguish
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // ALU operation codes carried to EX (RTYPE means "use funct")
  localparam logic [3:0] ALU_RTYPE = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_SUB   = 4'h2;
  localparam logic [3:0] ALU_AND   = 4'h3;
  localparam logic [3:0] ALU_OR    = 4'h4;
  localparam logic [3:0] ALU_XOR   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_LUI   = 4'h7;

  // Destination-register select
  localparam logic [1:0] RD_SEL_RT  = 2'd0;
  localparam logic [1:0] RD_SEL_RD  = 2'd1;
  localparam logic [1:0] RD_SEL_R31 = 2'd2;

  // Control word layout: {reg_dst[1:0], alu_src, alu_op[3:0], mem_read, mem_write, mem_to_reg, reg_write}
  localparam int CTRL_REG_DST_LSB = 9;
  localparam int CTRL_ALU_SRC     = 8;
  localparam int CTRL_ALU_OP_LSB  = 4;
  localparam int CTRL_MEM_READ    = 3;
  localparam int CTRL_MEM_WRITE   = 2;
  localparam int CTRL_MEM_TO_REG  = 1;
  localparam int CTRL_REG_WRITE   = 0;

  // Assemble a control word from its fields in the layout above
  function automatic logic [NB_CTRL-1:0] pack_ctrl(
    input logic [1:0] reg_dst,
    input logic       alu_src,
    input logic [3:0] alu_op,
    input logic       mem_read,
    input logic       mem_write,
    input logic       mem_to_reg,
    input logic       reg_write
  );
    return {reg_dst, alu_src, alu_op, mem_read, mem_write, mem_to_reg, reg_write};
  endfunction

endpackage

// File: rtl/decode_module_reg_file.sv
// 32x32 register file for the decode stage.
// r0 is hard-wired to zero; a write and a read of the same register in one
// cycle return the write data (write-through bypass).
// Optional feature: define DECODE_DEBUG_EN to add an asynchronous debug read port.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
`ifdef DECODE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage write on the rising edge; r0 never changes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i && (waddr_i != {ADDR_W{1'b0}})) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A with r0 forced to zero and same-cycle write bypass
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == {ADDR_W{1'b0}}) begin
      rdata_a_o = {DATA_W{1'b0}};
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end else begin
      rdata_a_o = mem_q[raddr_a_i];
    end
  end

  // Read port B with r0 forced to zero and same-cycle write bypass
  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == {ADDR_W{1'b0}}) begin
      rdata_b_o = {DATA_W{1'b0}};
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end else begin
      rdata_b_o = mem_q[raddr_b_i];
    end
  end

`ifdef DECODE_DEBUG_EN
  // Debug read of the stored value, independent of the pipeline
  always_comb begin
    if (dbg_addr_i == {ADDR_W{1'b0}}) begin
      dbg_data_o = {DATA_W{1'b0}};
    end else begin
      dbg_data_o = mem_q[dbg_addr_i];
    end
  end
`endif

endmodule

// File: rtl/decode_module.sv
// MIPS instruction-decode stage: control decode, register file, branch and
// jump resolution, hazard stalls, and the ID/EX pipeline register.
// Optional feature: define DECODE_DEBUG_EN to expose a register-file debug
// read port (i_dbg_reg_addr / o_dbg_reg_data).
module decode_module
  import mips_pkg::*;
#(
  parameter int NB_BITS = mips_pkg::NB_BITS,
  parameter int NB_REG  = mips_pkg::NB_REG,
  parameter int NB_CTRL = mips_pkg::NB_CTRL
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_if_id_pc,
  input  logic [NB_BITS-1:0] i_if_id_instr,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_BITS-1:0] i_wb_data,
  input  logic [NB_REG-1:0]  i_ex_mem_rd,
  input  logic               i_ex_mem_reg_write,
  input  logic               i_ex_mem_mem_read,
  input  logic [NB_BITS-1:0] i_ex_mem_alu_result,
  output logic [NB_BITS-1:0] o_brq_addr,
  output logic [NB_BITS-1:0] o_jmp_addr,
  output logic               o_ctr_beq,
  output logic               o_ctr_jmp,
  output logic               o_ctr_flush,
  output logic               o_pc_we,
  output logic               o_if_id_we,
  output logic [NB_BITS-1:0] o_id_ex_pc,
  output logic [NB_BITS-1:0] o_id_ex_rs_data,
  output logic [NB_BITS-1:0] o_id_ex_rt_data,
  output logic [NB_BITS-1:0] o_id_ex_imm,
  output logic [NB_REG-1:0]  o_id_ex_rs,
  output logic [NB_REG-1:0]  o_id_ex_rt,
  output logic [NB_REG-1:0]  o_id_ex_rd,
  output logic [NB_REG-1:0]  o_id_ex_shamt,
  output logic [5:0]         o_id_ex_funct,
  output logic [NB_CTRL-1:0] o_id_ex_ctrl
`ifdef DECODE_DEBUG_EN
  ,
  input  logic [NB_REG-1:0]  i_dbg_reg_addr,
  output logic [NB_BITS-1:0] o_dbg_reg_data
`endif
);

  localparam logic [NB_REG-1:0]  REG_ZERO  = {NB_REG{1'b0}};
  localparam logic [NB_REG-1:0]  REG_LINK  = {NB_REG{1'b1}};
  localparam logic [NB_CTRL-1:0] CTRL_NONE = {NB_CTRL{1'b0}};

  // Instruction fields
  logic [5:0]        opcode;
  logic [NB_REG-1:0] rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;

  assign opcode = i_if_id_instr[31:26];
  assign rs     = i_if_id_instr[25:21];
  assign rt     = i_if_id_instr[20:16];
  assign rd     = i_if_id_instr[15:11];
  assign shamt  = i_if_id_instr[10:6];
  assign funct  = i_if_id_instr[5:0];
  assign imm16  = i_if_id_instr[15:0];

  // Decode results
  logic [NB_CTRL-1:0] ctrl;
  logic [NB_BITS-1:0] imm_ext;
  logic [NB_BITS-1:0] imm_sext;
  logic uses_rs, uses_rt;
  logic is_beq, is_bne, is_j, is_jal, is_jr;

  // Register-file read data and branch comparator operands
  logic [NB_BITS-1:0] rs_data, rt_data;
  logic [NB_BITS-1:0] cmp_rs, cmp_rt;
  logic fwd_rs, fwd_rt, branch_taken, is_jump, uses_branch;

  // Hazard detection
  logic [NB_REG-1:0] id_ex_wreg;
  logic haz_load_use, haz_id_ex, haz_ex_mem, stall;

  // ID/EX pipeline register
  logic [NB_BITS-1:0] id_ex_pc_q, id_ex_rs_data_q, id_ex_rt_data_q, id_ex_imm_q;
  logic [NB_REG-1:0]  id_ex_rs_q, id_ex_rt_q, id_ex_rd_q, id_ex_shamt_q;
  logic [5:0]         id_ex_funct_q;
  logic [NB_CTRL-1:0] id_ex_ctrl_q, id_ex_ctrl_d;

  reg_file #(
    .DATA_W (NB_BITS),
    .ADDR_W (NB_REG)
  ) u_reg_file (
    .clk_i      (i_clk),
    .rst_ni     (i_rst),
    .we_i       (i_wb_we),
    .waddr_i    (i_wb_addr),
    .wdata_i    (i_wb_data),
    .raddr_a_i  (rs),
    .rdata_a_o  (rs_data),
    .raddr_b_i  (rt),
    .rdata_b_o  (rt_data)
`ifdef DECODE_DEBUG_EN
    ,
    .dbg_addr_i (i_dbg_reg_addr),
    .dbg_data_o (o_dbg_reg_data)
`endif
  );

  assign imm_sext = {{(NB_BITS-16){imm16[15]}}, imm16};

  // Main control decode: control word, register usage, branch/jump class, immediate
  always_comb begin
    ctrl    = CTRL_NONE;
    imm_ext = imm_sext;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rs = 1'b1;
        if (funct == FUNCT_JR) begin
          is_jr = 1'b1;
          ctrl  = CTRL_NONE;
        end else begin
          uses_rt = 1'b1;
          ctrl    = pack_ctrl(RD_SEL_RD, 1'b0, ALU_RTYPE, 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end
      OP_ADDI: begin
        uses_rs = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_SLTI: begin
        uses_rs = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_SLT, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_ANDI: begin
        uses_rs = 1'b1;
        imm_ext = {{(NB_BITS-16){1'b0}}, imm16};
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_ORI: begin
        uses_rs = 1'b1;
        imm_ext = {{(NB_BITS-16){1'b0}}, imm16};
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_OR, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_XORI: begin
        uses_rs = 1'b1;
        imm_ext = {{(NB_BITS-16){1'b0}}, imm16};
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_XOR, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_LUI: begin
        imm_ext = {imm16, {(NB_BITS-16){1'b0}}};
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_LUI, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      OP_LW: begin
        uses_rs = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      OP_SW: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b1, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      OP_BEQ: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_beq  = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_bne  = 1'b1;
        ctrl    = pack_ctrl(RD_SEL_RT, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      OP_J: begin
        is_j = 1'b1;
        ctrl = CTRL_NONE;
      end
      OP_JAL: begin
        is_jal = 1'b1;
        ctrl   = pack_ctrl(RD_SEL_R31, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      default: begin
        ctrl = CTRL_NONE;
      end
    endcase
  end

  // Branch comparator operands, forwarded from EX/MEM when it holds a finished ALU result
  always_comb begin
    fwd_rs = i_ex_mem_reg_write && !i_ex_mem_mem_read &&
             (i_ex_mem_rd != REG_ZERO) && (i_ex_mem_rd == rs);
    fwd_rt = i_ex_mem_reg_write && !i_ex_mem_mem_read &&
             (i_ex_mem_rd != REG_ZERO) && (i_ex_mem_rd == rt);
    if (fwd_rs) begin
      cmp_rs = i_ex_mem_alu_result;
    end else begin
      cmp_rs = rs_data;
    end
    if (fwd_rt) begin
      cmp_rt = i_ex_mem_alu_result;
    end else begin
      cmp_rt = rt_data;
    end
  end

  // Branch outcome and redirect targets
  always_comb begin
    branch_taken = (is_beq && (cmp_rs == cmp_rt)) || (is_bne && (cmp_rs != cmp_rt));
    is_jump      = is_j || is_jal || is_jr;
    uses_branch  = is_beq || is_bne || is_jr;
    o_brq_addr   = i_if_id_pc + {imm_sext[NB_BITS-3:0], 2'b00};
    if (is_jr) begin
      o_jmp_addr = cmp_rs;
    end else begin
      o_jmp_addr = {i_if_id_pc[NB_BITS-1:28], i_if_id_instr[25:0], 2'b00};
    end
  end

  // Destination register of the instruction currently in ID/EX
  always_comb begin
    case (id_ex_ctrl_q[CTRL_REG_DST_LSB +: 2])
      RD_SEL_RD:  id_ex_wreg = id_ex_rd_q;
      RD_SEL_R31: id_ex_wreg = REG_LINK;
      default:    id_ex_wreg = id_ex_rt_q;
    endcase
  end

  // Load-use and branch-operand hazard detection
  always_comb begin
    haz_load_use = id_ex_ctrl_q[CTRL_MEM_READ] && (id_ex_rt_q != REG_ZERO) &&
                   ((uses_rs && (rs == id_ex_rt_q)) || (uses_rt && (rt == id_ex_rt_q)));
    haz_id_ex    = uses_branch && id_ex_ctrl_q[CTRL_REG_WRITE] && (id_ex_wreg != REG_ZERO) &&
                   ((uses_rs && (rs == id_ex_wreg)) || (uses_rt && (rt == id_ex_wreg)));
    haz_ex_mem   = uses_branch && i_ex_mem_mem_read && (i_ex_mem_rd != REG_ZERO) &&
                   ((uses_rs && (rs == i_ex_mem_rd)) || (uses_rt && (rt == i_ex_mem_rd)));
    stall        = haz_load_use || haz_id_ex || haz_ex_mem;
  end

  // Fetch feedback: a stall freezes fetch and suppresses any redirect
  always_comb begin
    if (stall) begin
      o_pc_we      = 1'b0;
      o_if_id_we   = 1'b0;
      o_ctr_beq    = 1'b0;
      o_ctr_jmp    = 1'b0;
      o_ctr_flush  = 1'b0;
      id_ex_ctrl_d = CTRL_NONE;
    end else begin
      o_pc_we      = 1'b1;
      o_if_id_we   = 1'b1;
      o_ctr_beq    = branch_taken;
      o_ctr_jmp    = is_jump;
      o_ctr_flush  = branch_taken || is_jump;
      id_ex_ctrl_d = ctrl;
    end
  end

  // ID/EX pipeline register, loaded every cycle (bubble control on stall)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      id_ex_pc_q      <= {NB_BITS{1'b0}};
      id_ex_rs_data_q <= {NB_BITS{1'b0}};
      id_ex_rt_data_q <= {NB_BITS{1'b0}};
      id_ex_imm_q     <= {NB_BITS{1'b0}};
      id_ex_rs_q      <= REG_ZERO;
      id_ex_rt_q      <= REG_ZERO;
      id_ex_rd_q      <= REG_ZERO;
      id_ex_shamt_q   <= REG_ZERO;
      id_ex_funct_q   <= 6'd0;
      id_ex_ctrl_q    <= CTRL_NONE;
    end else begin
      id_ex_pc_q      <= i_if_id_pc;
      id_ex_rs_data_q <= rs_data;
      id_ex_rt_data_q <= rt_data;
      id_ex_imm_q     <= imm_ext;
      id_ex_rs_q      <= rs;
      id_ex_rt_q      <= rt;
      id_ex_rd_q      <= rd;
      id_ex_shamt_q   <= shamt;
      id_ex_funct_q   <= funct;
      id_ex_ctrl_q    <= id_ex_ctrl_d;
    end
  end

  assign o_id_ex_pc      = id_ex_pc_q;
  assign o_id_ex_rs_data = id_ex_rs_data_q;
  assign o_id_ex_rt_data = id_ex_rt_data_q;
  assign o_id_ex_imm     = id_ex_imm_q;
  assign o_id_ex_rs      = id_ex_rs_q;
  assign o_id_ex_rt      = id_ex_rt_q;
  assign o_id_ex_rd      = id_ex_rd_q;
  assign o_id_ex_shamt   = id_ex_shamt_q;
  assign o_id_ex_funct   = id_ex_funct_q;
  assign o_id_ex_ctrl    = id_ex_ctrl_q;

endmodule

// File: tb/tb_decode_module.sv
// Directed self-checking bench for decode_module.
module tb_decode_module;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_pc, if_id_instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_reg_write, ex_mem_mem_read;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] brq_addr, jmp_addr;
  logic        ctr_beq, ctr_jmp, ctr_flush, pc_we, if_id_we;
  logic [31:0] id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
  logic [5:0]  id_ex_funct;
  logic [10:0] id_ex_ctrl;
`ifdef DECODE_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  decode_module dut (
    .i_clk               (clk),
    .i_rst               (rst_n),
    .i_if_id_pc          (if_id_pc),
    .i_if_id_instr       (if_id_instr),
    .i_wb_we             (wb_we),
    .i_wb_addr           (wb_addr),
    .i_wb_data           (wb_data),
    .i_ex_mem_rd         (ex_mem_rd),
    .i_ex_mem_reg_write  (ex_mem_reg_write),
    .i_ex_mem_mem_read   (ex_mem_mem_read),
    .i_ex_mem_alu_result (ex_mem_alu_result),
    .o_brq_addr          (brq_addr),
    .o_jmp_addr          (jmp_addr),
    .o_ctr_beq           (ctr_beq),
    .o_ctr_jmp           (ctr_jmp),
    .o_ctr_flush         (ctr_flush),
    .o_pc_we             (pc_we),
    .o_if_id_we          (if_id_we),
    .o_id_ex_pc          (id_ex_pc),
    .o_id_ex_rs_data     (id_ex_rs_data),
    .o_id_ex_rt_data     (id_ex_rt_data),
    .o_id_ex_imm         (id_ex_imm),
    .o_id_ex_rs          (id_ex_rs),
    .o_id_ex_rt          (id_ex_rt),
    .o_id_ex_rd          (id_ex_rd),
    .o_id_ex_shamt       (id_ex_shamt),
    .o_id_ex_funct       (id_ex_funct),
    .o_id_ex_ctrl        (id_ex_ctrl)
`ifdef DECODE_DEBUG_EN
    ,
    .i_dbg_reg_addr      (dbg_addr),
    .o_dbg_reg_data      (dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_cnt++;
    if (obs !== exp_v) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Present a new IF/ID instruction on the falling edge
  task automatic put(input logic [31:0] pc4, input logic [31:0] instr);
    @(negedge clk);
    if_id_pc    = pc4;
    if_id_instr = instr;
  endtask

  // Let the rising edge happen, then settle
  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if_id_pc = 32'h0; if_id_instr = 32'h0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0;
    ex_mem_alu_result = 32'h0;
`ifdef DECODE_DEBUG_EN
    dbg_addr = 5'd0;
`endif
    #1;
    chk("rst_ctrl", {21'h0, id_ex_ctrl}, 32'h0);
    chk("rst_pc", id_ex_pc, 32'h0);
    chk("rst_imm", id_ex_imm, 32'h0);
    chk("rst_pc_we", {31'h0, pc_we}, 32'h1);
    chk("rst_if_id_we", {31'h0, if_id_we}, 32'h1);
    chk("rst_ctr", {29'h0, ctr_beq, ctr_jmp, ctr_flush}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI r1,r0,5 with WB writing r1=5
    put(32'h4, 32'h2001_0005);
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    edge_tick();
    wb_we = 1'b0;
    chk("addi_imm", id_ex_imm, 32'd5);
    chk("addi_alu_src", {31'h0, id_ex_ctrl[CTRL_ALU_SRC]}, 32'h1);
    chk("addi_reg_write", {31'h0, id_ex_ctrl[CTRL_REG_WRITE]}, 32'h1);
    chk("addi_reg_dst", {30'h0, id_ex_ctrl[CTRL_REG_DST_LSB +: 2]}, 32'h0);
    chk("addi_rt", {27'h0, id_ex_rt}, 32'd1);
    chk("addi_pc", id_ex_pc, 32'h4);

    // ADD r3,r2,r0 with same-cycle WB r2=0x1234
    put(32'h8, 32'h0040_1820);
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
    edge_tick();
    wb_we = 1'b0;
    chk("add_bypass", id_ex_rs_data, 32'h1234);
    chk("add_rd", {27'h0, id_ex_rd}, 32'd3);
    chk("add_funct", {26'h0, id_ex_funct}, 32'h20);
    chk("add_reg_dst", {30'h0, id_ex_ctrl[CTRL_REG_DST_LSB +: 2]}, 32'h1);

    // LW r4,0(r0) then ADD r5,r4,r4: one stall cycle
    put(32'hC, 32'h8C04_0000);
    edge_tick();
    chk("lw_mem_read", {31'h0, id_ex_ctrl[CTRL_MEM_READ]}, 32'h1);
    put(32'h10, 32'h0084_2820);
    #1;
    chk("lu_pc_we", {31'h0, pc_we}, 32'h0);
    chk("lu_if_id_we", {31'h0, if_id_we}, 32'h0);
    edge_tick();
    chk("lu_bubble", {21'h0, id_ex_ctrl}, 32'h0);
    put(32'h10, 32'h0084_2820);
    #1;
    chk("lu_release", {31'h0, pc_we}, 32'h1);
    edge_tick();
    chk("lu_add_rw", {31'h0, id_ex_ctrl[CTRL_REG_WRITE]}, 32'h1);
    chk("lu_add_rd", {27'h0, id_ex_rd}, 32'd5);

    // BEQ r1,r1,+3 at PC+4=0x20: taken
    put(32'h20, 32'h1021_0003);
    #1;
    chk("beq_taken", {31'h0, ctr_beq}, 32'h1);
    chk("beq_flush", {31'h0, ctr_flush}, 32'h1);
    chk("beq_target", brq_addr, 32'h2C);
    chk("beq_no_jmp", {31'h0, ctr_jmp}, 32'h0);
    edge_tick();
    chk("beq_rw", {31'h0, id_ex_ctrl[CTRL_REG_WRITE]}, 32'h0);

    // BNE r1,r1: not taken
    put(32'h24, 32'h1421_0003);
    #1;
    chk("bne_not_taken", {30'h0, ctr_beq, ctr_flush}, 32'h0);
    edge_tick();

    // ADDI r1,r0,7 then BEQ r1,r1: stall from ID/EX writer
    put(32'h28, 32'h2001_0007);
    edge_tick();
    put(32'h20, 32'h1021_0003);
    #1;
    chk("beqh_pc_we", {31'h0, pc_we}, 32'h0);
    chk("beqh_beq", {30'h0, ctr_beq, ctr_flush}, 32'h0);
    edge_tick();
    chk("beqh_bubble", {21'h0, id_ex_ctrl}, 32'h0);
    put(32'h20, 32'h1021_0003);
    ex_mem_rd = 5'd1; ex_mem_reg_write = 1'b1; ex_mem_alu_result = 32'd7;
    #1;
    chk("beqh_go_pc_we", {31'h0, pc_we}, 32'h1);
    chk("beqh_go_beq", {31'h0, ctr_beq}, 32'h1);
    chk("beqh_go_target", brq_addr, 32'h2C);
    edge_tick();

    // BEQ r1,r0 with r1 forwarded as 0 from EX/MEM: taken only via forwarding
    put(32'h30, 32'h1020_0003);
    ex_mem_alu_result = 32'd0;
    #1;
    chk("fwd_beq", {31'h0, ctr_beq}, 32'h1);
    chk("fwd_target", brq_addr, 32'h3C);
    edge_tick();

    // BEQ r1,r1 while EX/MEM loads r1: stall
    put(32'h34, 32'h1021_0003);
    ex_mem_mem_read = 1'b1;
    #1;
    chk("exmem_ld_stall", {31'h0, pc_we}, 32'h0);
    edge_tick();
    ex_mem_rd = 5'd0; ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0;

    // JAL 0x40 at PC+4=0x10
    put(32'h10, 32'h0C00_0040);
    #1;
    chk("jal_jmp", {31'h0, ctr_jmp}, 32'h1);
    chk("jal_flush", {31'h0, ctr_flush}, 32'h1);
    chk("jal_target", jmp_addr, 32'h100);
    edge_tick();
    chk("jal_reg_dst", {30'h0, id_ex_ctrl[CTRL_REG_DST_LSB +: 2]}, 32'h2);
    chk("jal_reg_write", {31'h0, id_ex_ctrl[CTRL_REG_WRITE]}, 32'h1);
    chk("jal_pc", id_ex_pc, 32'h10);

    // JR r1 (r1 = 5 in the register file)
    put(32'h104, 32'h0020_0008);
    #1;
    chk("jr_jmp", {31'h0, ctr_jmp}, 32'h1);
    chk("jr_target", jmp_addr, 32'h5);
    edge_tick();
    chk("jr_reg_write", {31'h0, id_ex_ctrl[CTRL_REG_WRITE]}, 32'h0);

    // Immediate extension variants and an unknown opcode
    put(32'h40, 32'h3006_FFFF);
    edge_tick();
    chk("andi_zext", id_ex_imm, 32'h0000_FFFF);
    put(32'h44, 32'h2006_FFFF);
    edge_tick();
    chk("addi_sext", id_ex_imm, 32'hFFFF_FFFF);
    put(32'h48, 32'h3C06_1234);
    edge_tick();
    chk("lui_imm", id_ex_imm, 32'h1234_0000);
    put(32'h4C, 32'hFC00_0000);
    edge_tick();
    chk("undef_ctrl", {21'h0, id_ex_ctrl}, 32'h0);

    // Reset asserted during a load-use stall
    put(32'h50, 32'h8C04_0000);
    edge_tick();
    put(32'h54, 32'h0084_2820);
    #1;
    chk("rst_stall_pre", {31'h0, pc_we}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {21'h0, id_ex_ctrl}, 32'h0);
    chk("rst_async_pc", id_ex_pc, 32'h0);
    chk("rst_async_rt", {27'h0, id_ex_rt}, 32'h0);
    chk("rst_async_pc_we", {31'h0, pc_we}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    // ADD r3,r1,r0: r1 was cleared by reset
    put(32'h58, 32'h0020_1820);
    edge_tick();
    chk("rst_rf_clear", id_ex_rs_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
